uart_tx_fifo_feeder: RTL
========================

Name: uart_tx_fifo_feeder

Overview:
- Synchronous byte FIFO plus launch FSM between the system write side and the UART transmitter.
- Accepts bytes from a producer at any rate.
- Presents them one at a time on TX_P_DATA/TXDATA_VALID.
- Paces launches with the transmitter's TX_BUSY so no byte is lost or sent twice.

Parameters:
- DATA_W, 8, byte width; must equal the transmitter data width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- BUSY_TO, 4, cycles to wait for TX_BUSY to rise after a launch before the byte is treated as consumed.

Ports:
- clk  in  1  clock.
- ARSTn  in  1  asynchronous reset, active low.
- WR_EN  in  1  producer write strobe.
- WR_DATA  in  DATA_W  producer byte.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- COUNT  out  $clog2(DEPTH)+1  occupancy.
- OVERFLOW  out  1  one-cycle pulse: write dropped because FULL.
- TX_BUSY  in  1  transmitter busy.
- TX_P_DATA  out  DATA_W  byte to transmitter, registered.
- TXDATA_VALID  out  1  one-cycle launch strobe to transmitter.

Behaviour:
- Reset (ARSTn=0, async): pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_P_DATA=0, TXDATA_VALID=0, state=IDLE. Storage array is not reset.
- Reset mid-transfer: the in-flight byte and all queued bytes are discarded.
- Write: when WR_EN=1 and FULL=0, WR_DATA is stored at the write pointer and the pointer increments (wraps at DEPTH).
- Write while FULL: when WR_EN=1 and FULL=1, nothing is stored and OVERFLOW=1 next cycle for exactly one cycle.
- FULL/EMPTY/COUNT: registered from the pointers; extra-MSB pointer compare.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE.
- IDLE: if EMPTY=0 and TX_BUSY=0, load the head entry into TX_P_DATA, increment the read pointer, go to LAUNCH. Otherwise stay.
- LAUNCH: TXDATA_VALID=1 for this single cycle; next state WAIT_BUSY.
- WAIT_BUSY: if TX_BUSY=1, go to WAIT_IDLE. Otherwise increment a timeout counter; when it reaches BUSY_TO, go to IDLE (byte counted as sent).
- WAIT_IDLE: stay while TX_BUSY=1; on TX_BUSY=0, go to IDLE.
- TX_P_DATA holds its value from the load until the next load.
- Latency from write into an empty FIFO with the transmitter idle: WR_EN at cycle N; COUNT=1 at N+1; TXDATA_VALID=1 at N+2.
- Back-to-back throughput: one byte per transmitter frame plus 2 cycles of FSM overhead (WAIT_IDLE->IDLE->LAUNCH).
- Simultaneous write and pop: both take effect and COUNT is unchanged.
- Write while FULL with a simultaneous pop: the write is still rejected, because FULL is registered state.
- TX_BUSY=1 while in IDLE: no launch.

Optional Feature:
- Macro UART_TX_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds parameter AF_THRESH (default 12).
  - Adds output ALMOST_FULL (1 bit), registered, =1 when COUNT >= AF_THRESH; reset 0.
- Undefined:
  - Neither the port nor the parameter exists.
  - All other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - Localparam UART_DATA_W=8.
  - Typedef for the FSM state enum (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_IDLE=2'd3).
  - Default DEPTH.
- One sub-module, uart_sync_fifo:
  - Owns storage, pointers, FULL/EMPTY/COUNT/OVERFLOW.
  - Pop interface is a single rd_en with rd_data valid in the same cycle.
- The top instantiates it plus the launch FSM and the timeout counter.

Test Plan:
- Single byte: after reset, WR_EN with 0xA5 at cycle 5, TX_BUSY=0 -> TXDATA_VALID=1 only at cycle 7 with TX_P_DATA=0xA5. Then model TX_BUSY=1 for 100 cycles -> no further strobe, EMPTY=1.
- Burst: write 0x01..0x10 (16 bytes) consecutively -> FULL=1, COUNT=16.
- Overflow: in the Burst state, a 17th write of 0xFF -> OVERFLOW pulses once and 0xFF is never launched. The bytes are launched in order 0x01..0x10, one per TX_BUSY high/low cycle.
- Timeout: TX_BUSY tied 0, two bytes 0x11, 0x22 queued -> launches spaced 1+BUSY_TO+1 cycles apart (6 with default), each strobe exactly one cycle.
- Simultaneous: COUNT=3, WR_EN=1 in the same cycle the FSM pops in IDLE -> COUNT stays 3 and the write pointer and read pointer each advance by 1.
- Reset mid-operation: drop ARSTn during WAIT_IDLE with COUNT=5 -> outputs zero immediately (async). After release, EMPTY=1 and no TXDATA_VALID until a new write.
- With UART_TX_FIFO_ALMOST_FULL_EN, AF_THRESH=12: ALMOST_FULL=1 the cycle after the 12th write, and returns to 0 when COUNT drops to 11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: data width, default FIFO depth
// and the launch FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered FULL/EMPTY/COUNT and an overflow pulse.
// UART_TX_FIFO_ALMOST_FULL_EN adds AF_THRESH and a registered almost-full flag.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_FIFO_DEPTH
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    , parameter int unsigned AF_THRESH = 12
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    , output logic                   o_almost_full
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [AW:0]       w_wr_ptr_d;
    logic [AW:0]       w_rd_ptr_d;
    logic [AW:0]       w_count_d;
    logic              w_push;
    logic              w_pop;

    assign w_push     = i_wr_en && !r_full;
    assign w_pop      = i_rd_en && !r_empty;
    assign w_wr_ptr_d = w_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    assign w_rd_ptr_d = w_pop ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    assign w_count_d  = w_wr_ptr_d - w_rd_ptr_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Flags are computed from next-state pointers so they line up with the pointer update.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_count    <= w_count_d;
            r_full     <= (w_wr_ptr_d[AW] != w_rd_ptr_d[AW]) &&
                          (w_wr_ptr_d[AW-1:0] == w_rd_ptr_d[AW-1:0]);
            r_empty    <= (w_wr_ptr_d == w_rd_ptr_d);
            r_overflow <= i_wr_en && r_full;
        end
    end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);

    logic r_almost_full;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_d >= AF_LVL);
        end
    end

    assign o_almost_full = r_almost_full;
`endif

    assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus launch FSM that hands one byte at a time to a UART transmitter,
// paced by TX_BUSY. UART_TX_FIFO_ALMOST_FULL_EN adds AF_THRESH and ALMOST_FULL.
module uart_tx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W  = UART_DATA_W,
    parameter int unsigned DEPTH   = UART_FIFO_DEPTH,
    parameter int unsigned BUSY_TO = 4
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    , parameter int unsigned AF_THRESH = 12
`endif
) (
    input  logic                     clk,
    input  logic                     ARSTn,
    input  logic                     WR_EN,
    input  logic [DATA_W-1:0]        WR_DATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    input  logic                     TX_BUSY,
    output logic [DATA_W-1:0]        TX_P_DATA,
    output logic                     TXDATA_VALID
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    , output logic                   ALMOST_FULL
`endif
);

    localparam int unsigned   TW      = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    tx_state_e         r_state;
    logic [TW-1:0]     r_to_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_empty;
    logic              w_pop;

    assign w_pop = (r_state == IDLE) && !w_empty && !TX_BUSY;

    uart_sync_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH)
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        , .AF_THRESH (AF_THRESH)
`endif
    ) u_fifo (
        .i_clk      (clk),
        .i_arst_n   (ARSTn),
        .i_wr_en    (WR_EN),
        .i_wr_data  (WR_DATA),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_data),
        .o_full     (FULL),
        .o_empty    (w_empty),
        .o_count    (COUNT),
        .o_overflow (OVERFLOW)
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        , .o_almost_full (ALMOST_FULL)
`endif
    );

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_state    <= IDLE;
            r_to_cnt   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_rd_data;
                        r_tx_valid <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= WAIT_BUSY;
                end
                // A transmitter that never raises busy still consumes the byte after BUSY_TO.
                WAIT_BUSY: begin
                    if (TX_BUSY) begin
                        r_state <= WAIT_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (!TX_BUSY) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign EMPTY        = w_empty;
    assign TX_P_DATA    = r_tx_data;
    assign TXDATA_VALID = r_tx_valid;

endmodule
